audio_mix_scheduler: RTL and testbench

Sample-rate scheduler and mixer controller for the stereo-less mono audio path feeding the delta-sigma audio output.
- Generates the sample tick from a fractional clock ratio (factor_mul/factor_div), exactly like the audio object's rate setting.
- On each tick, polls VOICES sample sources round-robin over a req/ack handshake and time-shares one multiply-accumulate unit across them.
- Emits one saturated mixed sample per tick.

---
 rtl/audio_mix_scheduler.sv | 172 +++++++++++++++++
 tb/tb_audio_mix_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_scheduler.sv
// Sample-rate scheduler and mono mixer: a fractional tick generator starts a frame that polls
// each voice over req/ack, multiply-accumulates it against its gain and emits a saturated sample.
module audio_mix_scheduler #(
    parameter int VOICES       = 4,
    parameter int SAMPLE_WIDTH = 16,
    parameter int VOL_WIDTH    = 8,
    parameter int TIMEOUT      = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    factor_mul,
    input  logic [31:0]                    factor_div,
    output logic [VOICES-1:0]              voice_req,
    input  logic [VOICES-1:0]              voice_ack,
    input  logic [VOICES*SAMPLE_WIDTH-1:0] voice_sample,
    input  logic                           vol_we,
    input  logic [7:0]                     vol_addr,
    input  logic [VOL_WIDTH-1:0]           vol_data,
    input  logic                           err_clr,
    output logic [SAMPLE_WIDTH-1:0]        mix_out,
    output logic                           mix_valid,
    output logic                           busy,
    output logic                           err_overrun,
    output logic                           err_timeout
);
    localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int AW = SAMPLE_WIDTH + VOL_WIDTH + $clog2(VOICES) + 1;
    localparam int PW = SAMPLE_WIDTH + VOL_WIDTH + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_MAC, S_OUT} state_t;

    state_t                                r_state;
    logic [32:0]                           r_phase;
    logic                                  r_tick;
    logic [IW-1:0]                         r_idx;
    logic [TW-1:0]                         r_wait;
    logic signed [SAMPLE_WIDTH-1:0]        r_sample;
    logic signed [AW-1:0]                  r_acc;
    logic [VOICES-1:0][VOL_WIDTH-1:0]      r_vol;
    logic [VOICES-1:0]                     r_req;
    logic [SAMPLE_WIDTH-1:0]               r_mix;
    logic                                  r_valid;
    logic                                  r_busy;
    logic                                  r_err_ov;
    logic                                  r_err_to;

    logic [33:0]                           w_sum;
    logic [33:0]                           w_diff;
    logic                                  w_hit;
    logic signed [VOL_WIDTH:0]             w_vol;
    logic signed [PW-1:0]                  w_prod;
    logic signed [AW-1:0]                  w_shift;
    logic signed [AW-1:0]                  w_max;
    logic signed [AW-1:0]                  w_min;
    logic [SAMPLE_WIDTH-1:0]               w_sat;
    logic                                  w_ack;
    logic                                  w_to_set;
    logic                                  w_ov_set;
    logic                                  w_addr_ok;
    logic                                  w_last;

    // 34-bit sum so p + factor_mul never wraps even after factor_div shrinks
    assign w_sum  = {1'b0, r_phase} + {2'b0, factor_mul};
    assign w_diff = w_sum - {2'b0, factor_div};
    assign w_hit  = (factor_div != 32'd0) && (w_sum >= {2'b0, factor_div});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= '0;
            r_tick  <= 1'b0;
        end else if (factor_div == 32'd0) begin
            r_phase <= '0;
            r_tick  <= 1'b0;
        end else if (w_hit) begin
            r_phase <= w_diff[32:0];
            r_tick  <= 1'b1;
        end else begin
            r_phase <= w_sum[32:0];
            r_tick  <= 1'b0;
        end
    end

    assign w_vol   = {1'b0, r_vol[r_idx]};
    assign w_prod  = PW'(r_sample) * PW'(w_vol);
    assign w_shift = r_acc >>> VOL_WIDTH;
    assign w_max   = {{(AW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    assign w_min   = {{(AW-SAMPLE_WIDTH+1){1'b1}}, {(SAMPLE_WIDTH-1){1'b0}}};
    assign w_sat   = (w_shift > w_max) ? w_max[SAMPLE_WIDTH-1:0] :
                     (w_shift < w_min) ? w_min[SAMPLE_WIDTH-1:0] : w_shift[SAMPLE_WIDTH-1:0];

    assign w_ack     = voice_ack[r_idx];
    assign w_last    = (r_idx == IW'(VOICES-1));
    assign w_to_set  = (r_state == S_REQ) && !w_ack && (r_wait == TW'(TIMEOUT-1));
    assign w_ov_set  = r_tick && (r_state != S_IDLE);
    assign w_addr_ok = ({24'd0, vol_addr} < 32'(VOICES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_wait   <= '0;
            r_sample <= '0;
            r_acc    <= '0;
            r_vol    <= '0;
            r_req    <= '0;
            r_mix    <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_err_ov <= 1'b0;
            r_err_to <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // a new error event in the same cycle as err_clr keeps the flag set
            if (w_ov_set)     r_err_ov <= 1'b1;
            else if (err_clr) r_err_ov <= 1'b0;
            if (w_to_set)     r_err_to <= 1'b1;
            else if (err_clr) r_err_to <= 1'b0;
            if (vol_we && w_addr_ok)
                r_vol[vol_addr[IW-1:0]] <= vol_data;

            case (r_state)
                S_IDLE: if (r_tick) begin
                    r_idx   <= '0;
                    r_acc   <= '0;
                    r_wait  <= '0;
                    r_req   <= VOICES'(1);
                    r_busy  <= 1'b1;
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (w_ack) begin
                        r_sample <= voice_sample[32'(r_idx)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                        r_req    <= '0;
                        r_state  <= S_MAC;
                    end else if (r_wait == TW'(TIMEOUT-1)) begin
                        r_sample <= '0;
                        r_req    <= '0;
                        r_state  <= S_MAC;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + AW'(w_prod);
                    if (w_last) begin
                        r_state <= S_OUT;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_wait  <= '0;
                        r_req   <= VOICES'(1) << (r_idx + 1'b1);
                        r_state <= S_REQ;
                    end
                end
                S_OUT: begin
                    r_mix   <= w_sat;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign voice_req   = r_req;
    assign mix_out     = r_mix;
    assign mix_valid   = r_valid;
    assign busy        = r_busy;
    assign err_overrun = r_err_ov;
    assign err_timeout = r_err_to;
endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Bench for audio_mix_scheduler: vector table, random frames against an arithmetic mixing model,
// plus tick-rate, overrun and mid-frame reset sequences.
module tb_audio_mix_scheduler;
    localparam int V  = 4;
    localparam int SW = 16;
    localparam int VW = 8;
    localparam int TO = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [31:0]            fmul, fdiv;
    logic [V-1:0]           voice_req, voice_ack, ack_en;
    logic [V*SW-1:0]        voice_sample;
    logic                   vol_we, err_clr;
    logic [7:0]             vol_addr;
    logic [VW-1:0]          vol_data;
    logic signed [SW-1:0]   mix_out;
    logic                   mix_valid, busy, err_overrun, err_timeout;

    int checks = 0;
    int failures = 0;

    logic [VW-1:0]        mvol [V];
    logic signed [SW-1:0] msmp [V];

    typedef struct {
        logic [V-1:0][VW-1:0] v;
        logic [V-1:0][SW-1:0] s;
        logic [V-1:0]         ackm;
        int                   exp;
    } vec_t;
    vec_t tbl [7];

    always #5 clk = ~clk;
    // sources ack level-wise; acks on voices not being requested must be ignored
    assign voice_ack = ack_en;

    audio_mix_scheduler #(.VOICES(V), .SAMPLE_WIDTH(SW), .VOL_WIDTH(VW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .factor_mul(fmul), .factor_div(fdiv),
        .voice_req(voice_req), .voice_ack(voice_ack), .voice_sample(voice_sample),
        .vol_we(vol_we), .vol_addr(vol_addr), .vol_data(vol_data), .err_clr(err_clr),
        .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy),
        .err_overrun(err_overrun), .err_timeout(err_timeout));

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int ref_mix(input logic [V-1:0] ackm);
        longint sum = 0;
        for (int i = 0; i < V; i++)
            if (ackm[i]) sum += longint'(msmp[i]) * longint'({1'b0, mvol[i]});
        sum = sum >>> VW;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        return int'(sum);
    endfunction

    task automatic write_vol(input int a, input int d);
        vol_we = 1'b1; vol_addr = 8'(a); vol_data = VW'(d);
        @(negedge clk);
        vol_we = 1'b0;
        if (a < V) mvol[a] = VW'(d);
    endtask

    task automatic load_samples();
        for (int i = 0; i < V; i++) voice_sample[i*SW +: SW] = msmp[i];
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    // one-cycle tick, then wait for the frame; latency counted in cycles from the tick edge's setup
    task automatic run_frame(input int exp_mix, input logic [V-1:0] ackm, input bit per_voice);
        int cnt;
        int rq [V];
        int exp_lat;
        exp_lat = 11 + (TO - 1) * (V - $countones(ackm));
        for (int i = 0; i < V; i++) rq[i] = 0;
        fmul = 32'd1; fdiv = 32'd1;
        @(negedge clk);
        fdiv = 32'd0;
        cnt = 1;
        while (!mix_valid && cnt < 400) begin
            @(negedge clk);
            cnt++;
            for (int i = 0; i < V; i++) if (voice_req[i]) rq[i]++;
            if (cnt == 2) chk("busy_during", busy, 1);
        end
        chk("frame_done", mix_valid, 1);
        chk("latency", cnt, exp_lat);
        chk("mix_out", int'(mix_out), exp_mix);
        chk("busy_after", busy, 0);
        if (per_voice)
            for (int i = 0; i < V; i++) chk($sformatf("req_cycles_v%0d", i), rq[i], ackm[i] ? 1 : TO);
        @(negedge clk);
        chk("valid_pulse", mix_valid, 0);
    endtask

    initial begin
        int first, nv, last, bad_sp, bad_mix, glitch, cnt;
        logic [V-1:0] am;

        tbl[0] = '{v: {4{8'd128}}, s: {16'(100), 16'(-500), 16'(2000), 16'(1000)}, ackm: 4'hF, exp: 1300};
        tbl[1] = '{v: {4{8'd255}}, s: {4{16'(32767)}}, ackm: 4'hF, exp: 32767};
        tbl[2] = '{v: {4{8'd255}}, s: {4{16'(-32768)}}, ackm: 4'hF, exp: -32768};
        tbl[3] = '{v: {4{8'd128}}, s: {16'(100), 16'(-500), 16'(2000), 16'(1000)}, ackm: 4'b1011, exp: 1550};
        tbl[4] = '{v: {8'd8, 8'd16, 8'd32, 8'd64}, s: {16'(-1000), 16'(1000), 16'(-100), 16'(100)}, ackm: 4'hF, exp: 43};
        tbl[5] = '{v: {4{8'd1}}, s: {16'(0), 16'(0), 16'(0), 16'(-1)}, ackm: 4'hF, exp: -1};
        tbl[6] = '{v: {4{8'd0}}, s: {16'(4), 16'(3), 16'(2), 16'(1)}, ackm: 4'b0001, exp: 0};

        reset = 1'b0; fmul = 32'd3; fdiv = 32'd1000; ack_en = '1;
        vol_we = 1'b0; vol_addr = '0; vol_data = '0; err_clr = 1'b0; voice_sample = '0;
        for (int i = 0; i < V; i++) begin mvol[i] = '0; msmp[i] = '0; end
        repeat (3) @(negedge clk);
        chk("rst_req", voice_req, 0);
        chk("rst_mix", mix_out, 0);
        chk("rst_valid", mix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_errs", {err_overrun, err_timeout}, 0);

        // tick rate 3/1000: first tick in cycle 334, frame done 10 cycles later
        reset = 1'b1;
        first = -1; nv = 0;
        for (int c = 1; c <= 10010; c++) begin
            @(negedge clk);
            if (mix_valid) begin
                nv++;
                if (first < 0) first = c;
            end
        end
        chk("first_mix_cycle", first, 344);
        chk("frames_per_10k", nv, 30);
        fdiv = 32'd0; nv = 0;
        repeat (2000) begin @(negedge clk); if (mix_valid) nv++; end
        chk("div0_no_frames", nv, 0);

        for (int k = 0; k < 7; k++) begin
            pulse_clr();
            chk("err_clr", {err_overrun, err_timeout}, 0);
            for (int i = 0; i < V; i++) write_vol(i, int'(tbl[k].v[i]));
            for (int i = 0; i < V; i++) msmp[i] = $signed(tbl[k].s[i]);
            load_samples();
            ack_en = tbl[k].ackm;
            run_frame(tbl[k].exp, tbl[k].ackm, 1'b1);
            chk("err_timeout", err_timeout, (tbl[k].ackm != '1) ? 1 : 0);
        end

        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < V; i++) write_vol(i, int'($urandom_range(0, 255)));
            for (int i = 0; i < V; i++) msmp[i] = SW'($urandom);
            if (k % 5 == 0) for (int i = 0; i < V; i++) msmp[i] = (k % 10 == 0) ? 16'sh7fff : 16'sh8000;
            load_samples();
            am = ($urandom_range(0, 3) == 0) ? V'($urandom) : '1;
            ack_en = am;
            run_frame(ref_mix(am), am, 1'b0);
        end

        // overrun: tick every 2 cycles, frames every 10; write to addr 7 must not touch any voice
        for (int i = 0; i < V; i++) write_vol(i, 128);
        msmp[0] = 1000; msmp[1] = 2000; msmp[2] = -500; msmp[3] = 100;
        load_samples();
        ack_en = '1;
        write_vol(7, 0);
        pulse_clr();
        fmul = 32'd1; fdiv = 32'd2;
        last = -1; nv = 0; bad_sp = 0; bad_mix = 0; glitch = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (!$onehot0(voice_req)) glitch++;
            if (mix_valid) begin
                nv++;
                if (last >= 0 && c - last != 10) bad_sp++;
                last = c;
                if (int'(mix_out) != ref_mix('1)) bad_mix++;
            end
        end
        fdiv = 32'd0;
        repeat (20) @(negedge clk);
        chk("overrun_flag", err_overrun, 1);
        chk("overrun_frames", nv, 9);
        chk("overrun_spacing_errs", bad_sp, 0);
        chk("overrun_mix_errs", bad_mix, 0);
        chk("req_glitches", glitch, 0);
        chk("addr7_ignored", int'(mix_out), 1300);

        // reset while voice 1 is being requested
        ack_en = 4'b1101;
        fmul = 32'd1; fdiv = 32'd1;
        @(negedge clk);
        fdiv = 32'd0;
        cnt = 0;
        while (!voice_req[1] && cnt < 50) begin @(negedge clk); cnt++; end
        chk("req1_seen", voice_req[1], 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_req", voice_req, 0);
        chk("mid_rst_mix", mix_out, 0);
        chk("mid_rst_valid", mix_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_errs", {err_overrun, err_timeout}, 0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < V; i++) mvol[i] = '0;
        ack_en = '1;
        nv = 0;
        repeat (20) begin @(negedge clk); if (mix_valid) nv++; end
        chk("no_valid_after_abort", nv, 0);
        run_frame(ref_mix('1), '1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
